// File: rtl/pipe_cleaner_pkg.sv
// Shared types for the pipe cleaner controller.
//   state_e : controller FSM states
//   cmd_e   : one-hot-free command encoding (at most one command per cycle)
//   T_*     : {head, side, barrier} sensor tuples used by the transition table
package pipe_cleaner_pkg;
  typedef enum logic [2:0] {
    ST_RESET, ST_FIRST_MOVE, ST_SEARCH, ST_ROTATE, ST_FOLLOW, ST_STAND_BY, ST_FAULT
  } state_e;

  typedef enum logic [1:0] {CMD_NONE, CMD_FRONT, CMD_TURN, CMD_REMOVE} cmd_e;

  localparam logic [2:0] T_010 = 3'b010;
  localparam logic [2:0] T_011 = 3'b011;
  localparam logic [2:0] T_110 = 3'b110;
endpackage

// File: rtl/pipe_cleaner_ctrl_if.sv
// Sensor/command bundle between the sensor front-end, the controller and the
// motor/brush drivers.
//   master : sensor side (drives sensors + follow_right, observes commands)
//   slave  : controller side
interface pipe_cleaner_ctrl_if #(parameter int STEP_W = 8);
  logic              head, left, right, under, barrier, follow_right;
  logic              front, turn, turn_dir, remove, done, fault;
  logic [STEP_W-1:0] steps;

  modport master (output head, left, right, under, barrier, follow_right,
                  input  front, turn, turn_dir, remove, done, fault, steps);
  modport slave  (input  head, left, right, under, barrier, follow_right,
                  output front, turn, turn_dir, remove, done, fault, steps);
endinterface

// File: rtl/pipe_cleaner_limit_cnt.sv
// Consecutive-event counter.
//   clock, reset : clock, synchronous active-high reset
//   inc          : event occurred this cycle
//   clr          : streak broken this cycle (wins over inc)
//   at_max       : count has reached MAX
module pipe_cleaner_limit_cnt #(
  parameter int MAX = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (inc && !at_max) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pipe_cleaner_ctrl.sv
// Wall-following pipe-cleaning robot controller with registered commands,
// runtime wall selection, remove/turn stall detection and a step odometer.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : sensors in (head/left/right/under/barrier/follow_right),
//                  commands out (front/turn/turn_dir/remove/done/fault/steps)
module pipe_cleaner_ctrl
  import pipe_cleaner_pkg::*;
#(
  parameter int REMOVE_MAX = 16,
  parameter int TURN_MAX   = 8,
  parameter int STEP_W     = 8
) (
  input logic                clock,
  input logic                reset,
  pipe_cleaner_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic              turn_dir_q, turn_dir_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              side;
  logic [2:0]        tup;
  logic              rem_at_max, turn_at_max;

  // Counters see the command being registered this edge, so at_max reflects
  // the streak of commands already issued.
  pipe_cleaner_limit_cnt #(.MAX(REMOVE_MAX)) u_rem_cnt (
    .clock(clock), .reset(reset),
    .inc(cmd_d == CMD_REMOVE), .clr(cmd_d != CMD_REMOVE), .at_max(rem_at_max));

  pipe_cleaner_limit_cnt #(.MAX(TURN_MAX)) u_turn_cnt (
    .clock(clock), .reset(reset),
    .inc(cmd_d == CMD_TURN), .clr(cmd_d != CMD_TURN), .at_max(turn_at_max));

  assign side = turn_dir_q ? bus.right : bus.left;
  assign tup  = {bus.head, side, bus.barrier};

  always_comb begin
    state_d    = state_q;
    cmd_d      = CMD_NONE;
    turn_dir_d = turn_dir_q;
    case (state_q)
      ST_RESET: begin
        state_d    = ST_FIRST_MOVE;
        turn_dir_d = bus.follow_right;
      end
      ST_STAND_BY, ST_FAULT: ;  // absorbing until reset
      default: begin
        if (bus.under && state_q != ST_FIRST_MOVE) state_d = ST_STAND_BY;
        else if (bus.head && bus.barrier)          state_d = ST_STAND_BY;
        else begin
          case (state_q)
            ST_FIRST_MOVE: begin
              if (tup == T_010)      begin state_d = ST_SEARCH; cmd_d = CMD_FRONT; end
              else if (tup == T_011) cmd_d = CMD_REMOVE;
              else                   cmd_d = CMD_TURN;
            end
            ST_SEARCH: begin
              case (tup)
                T_010:   cmd_d = CMD_FRONT;
                T_110:   begin state_d = ST_ROTATE; cmd_d = CMD_TURN;   end
                T_011:   begin state_d = ST_FOLLOW; cmd_d = CMD_REMOVE; end
                default: begin state_d = ST_FOLLOW; cmd_d = CMD_TURN;   end
              endcase
            end
            ST_ROTATE: begin
              case (tup)
                T_010:   begin state_d = ST_SEARCH; cmd_d = CMD_FRONT;  end
                T_011:   begin state_d = ST_FOLLOW; cmd_d = CMD_REMOVE; end
                default: cmd_d = CMD_TURN;
              endcase
            end
            ST_FOLLOW: begin
              // head&barrier already handled above, so head=1 implies barrier=0
              if (!bus.head) begin
                if (bus.barrier) cmd_d = CMD_REMOVE;
                else begin state_d = ST_SEARCH; cmd_d = CMD_FRONT; end
              end else begin
                cmd_d = CMD_TURN;
                if (side) state_d = ST_ROTATE;
              end
            end
            default: ;
          endcase
          // Stall: table wants one more remove/turn than allowed
          if ((cmd_d == CMD_REMOVE && rem_at_max) || (cmd_d == CMD_TURN && turn_at_max)) begin
            state_d = ST_FAULT;
            cmd_d   = CMD_NONE;
          end
        end
      end
    endcase

    steps_d = steps_q;
    if (cmd_d == CMD_FRONT && steps_q != {STEP_W{1'b1}}) steps_d = steps_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RESET;
      cmd_q      <= CMD_NONE;
      turn_dir_q <= 1'b0;
      steps_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      turn_dir_q <= turn_dir_d;
      steps_q    <= steps_d;
    end
  end

  assign bus.front    = (cmd_q == CMD_FRONT);
  assign bus.turn     = (cmd_q == CMD_TURN);
  assign bus.remove   = (cmd_q == CMD_REMOVE);
  assign bus.turn_dir = turn_dir_q;
  assign bus.done     = (state_q == ST_STAND_BY);
  assign bus.fault    = (state_q == ST_FAULT);
  assign bus.steps    = steps_q;
endmodule

// File: tb/tb_pipe_cleaner_ctrl.sv
module tb_pipe_cleaner_ctrl;
  localparam int RMAX = 4;
  localparam int TMAX = 8;

  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;

  pipe_cleaner_ctrl_if #(.STEP_W(8)) bus ();

  pipe_cleaner_ctrl #(.REMOVE_MAX(RMAX), .TURN_MAX(TMAX), .STEP_W(8)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));

  int checks = 0, passes = 0;
  bit armed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: states as small ints, command as which output is high.
  // 0 RESET 1 FIRST_MOVE 2 SEARCH 3 ROTATE 4 FOLLOW 5 STAND_BY 6 FAULT
  int m_st = 0, m_front = 0, m_turn = 0, m_rem = 0, m_dir = 0, m_steps = 0;
  int rem_run = 0, turn_run = 0;

  always @(posedge clock) begin
    int h, s, b, f, t, r;
    if (reset) begin
      m_st = 0; m_front = 0; m_turn = 0; m_rem = 0; m_dir = 0; m_steps = 0;
      rem_run = 0; turn_run = 0;
    end else begin
      h = bus.head; b = bus.barrier;
      s = m_dir ? bus.right : bus.left;
      f = 0; t = 0; r = 0;
      if (m_st == 0) begin
        m_st = 1; m_dir = bus.follow_right;
      end else if (m_st == 5 || m_st == 6) begin
      end else if (bus.under && m_st != 1) m_st = 5;
      else if (h && b) m_st = 5;
      else begin
        if (m_st == 1) begin
          if (!h && s && !b) begin f = 1; m_st = 2; end
          else if (!h && s && b) r = 1;
          else t = 1;
        end else if (m_st == 2) begin
          if (!h && s && !b) f = 1;
          else if (h && s && !b) begin t = 1; m_st = 3; end
          else if (!h && s && b) begin r = 1; m_st = 4; end
          else begin t = 1; m_st = 4; end
        end else if (m_st == 3) begin
          if (!h && s && !b) begin f = 1; m_st = 2; end
          else if (!h && s && b) begin r = 1; m_st = 4; end
          else t = 1;
        end else begin
          if (!h && b) r = 1;
          else if (!h) begin f = 1; m_st = 2; end
          else if (s) begin t = 1; m_st = 3; end
          else t = 1;
        end
        if ((r && rem_run == RMAX) || (t && turn_run == TMAX)) begin
          m_st = 6; f = 0; t = 0; r = 0;
        end
      end
      rem_run  = r ? rem_run + 1 : 0;
      turn_run = t ? turn_run + 1 : 0;
      if (f && m_steps < 255) m_steps++;
      m_front = f; m_turn = t; m_rem = r;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (armed) begin
      chk("front",    bus.front,    m_front);
      chk("turn",     bus.turn,     m_turn);
      chk("remove",   bus.remove,   m_rem);
      chk("turn_dir", bus.turn_dir, m_dir);
      chk("done",     bus.done,     m_st == 5);
      chk("fault",    bus.fault,    m_st == 6);
      chk("steps",    bus.steps,    m_steps);
      chk("onehot",   bus.front + bus.turn + bus.remove <= 1, 1);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic sensors(input bit h, l, r, u, b);
    bus.head = h; bus.left = l; bus.right = r; bus.under = u; bus.barrier = b;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    int n;
    sensors(0, 0, 0, 0, 0);
    bus.follow_right = 0;
    tick(); tick();
    armed = 1;

    // Reset state
    chk("rst_steps", bus.steps, 0);
    chk("rst_cmds", {bus.front, bus.turn, bus.remove, bus.done, bus.fault, bus.turn_dir}, 0);

    // Left wall straight run: no command, then 4 fronts
    reset = 0; sensors(0, 1, 0, 0, 0);
    tick();
    chk("first_cycle_idle", {bus.front, bus.turn, bus.remove}, 0);
    for (int i = 0; i < 4; i++) begin tick(); chk("run_front", bus.front, 1); end
    chk("run_steps", bus.steps, 4);
    chk("model_steps", m_steps, 4);

    // SEARCH -> ROTATE -> SEARCH
    sensors(1, 1, 0, 0, 0); tick(); chk("rotate_turn", bus.turn, 1);
    chk("model_rotate", m_st, 3);
    sensors(0, 1, 0, 0, 0); tick(); chk("back_front", bus.front, 1);

    // Endless removal -> FAULT after exactly RMAX removes
    sensors(0, 1, 0, 0, 1); do_reset();
    tick();
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); n += bus.remove; end
    chk("remove_count", n, 4);
    chk("remove_fault", bus.fault, 1);
    sensors(0, 1, 0, 1, 0); tick(); tick();
    chk("fault_sticky", {bus.fault, bus.done, bus.front, bus.turn, bus.remove}, 5'b10000);

    // Endless spinning -> FAULT after TMAX turns
    sensors(0, 0, 0, 0, 0); do_reset();
    tick();
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(); n += bus.turn; end
    chk("turn_count", n, 8);
    chk("turn_fault", bus.fault, 1);

    // Right-wall following; follow_right ignored outside RESET
    bus.follow_right = 1; sensors(0, 0, 1, 0, 0); do_reset();
    tick(); tick();
    chk("right_front", bus.front, 1);
    chk("right_dir", bus.turn_dir, 1);
    bus.follow_right = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("dir_held", bus.turn_dir, 1);
    chk("right_front2", bus.front, 1);

    // under beats a coincident remove limit in FOLLOW
    sensors(0, 1, 0, 0, 0); do_reset();
    tick(); tick();
    bus.barrier = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("follow_remove", bus.remove, 1);
    bus.under = 1; tick();
    chk("under_done", bus.done, 1);
    chk("under_nofault", bus.fault, 0);

    // Odometer saturation
    bus.follow_right = 0; sensors(0, 1, 0, 0, 0); do_reset();
    for (int i = 0; i < 262; i++) tick();
    chk("steps_sat", bus.steps, 255);
    chk("model_sat", m_steps, 255);
    chk("sat_front", bus.front, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.head    = ($urandom_range(0, 99) < 25);
      bus.left    = ($urandom_range(0, 99) < 60);
      bus.right   = ($urandom_range(0, 99) < 60);
      bus.under   = ($urandom_range(0, 99) < 3);
      bus.barrier = ($urandom_range(0, 99) < 30);
      bus.follow_right = $urandom_range(0, 1);
      reset = ($urandom_range(0, 99) < 3);
      tick();
    end
    reset = 0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
